// File: rtl/stall_ctrl_if.sv
// Stall controller bus: stage stall requests in, stall vector and EX sequencing status out.
interface stall_ctrl_if;
  logic        id_stallreq;
  logic        ex_mul_start;
  logic        ex_div_start;
  logic        mem_stallreq;
  logic        flush;
  logic [5:0]  stall;
  logic        ex_busy;
  logic        ex_done;
  logic [31:0] stall_cnt;

  modport master (
    output id_stallreq, ex_mul_start, ex_div_start, mem_stallreq, flush,
    input  stall, ex_busy, ex_done, stall_cnt
  );

  modport slave (
    input  id_stallreq, ex_mul_start, ex_div_start, mem_stallreq, flush,
    output stall, ex_busy, ex_done, stall_cnt
  );
endinterface

// File: rtl/stall_ctrl.sv
// Central pipeline stall controller with multi-cycle EX sequencer.
// Optional stall-cycle performance counter enabled by defining STALL_PERF_EN.
module stall_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input logic        clk,
  input logic        rst,
  stall_ctrl_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [7:0] MUL_LOAD = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);

  state_t     state_r, state_s;
  logic [7:0] cnt_r, cnt_s;
  logic       ex_req_s;
  logic       mem_req_s;
  logic [5:0] stall_s;
  logic       ex_busy_s;
  logic       ex_done_s;

  // State and countdown register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state, EX request and status decode
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    ex_req_s  = 1'b0;
    ex_busy_s = 1'b0;
    ex_done_s = 1'b0;
    mem_req_s = bus.mem_stallreq;
    case (state_r)
      IDLE: begin
        if (bus.ex_div_start) begin
          ex_req_s = 1'b1;
          state_s  = BUSY;
          cnt_s    = DIV_LOAD;
        end else if (bus.ex_mul_start) begin
          ex_req_s = 1'b1;
          state_s  = BUSY;
          cnt_s    = MUL_LOAD;
        end else begin
          state_s  = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r != 8'd0) begin
          ex_req_s  = 1'b1;
          ex_busy_s = 1'b1;
          cnt_s     = cnt_r - 8'd1;
        end else begin
          // Result stays valid until MEM lets the EX instruction advance
          ex_done_s = 1'b1;
          if (!bus.mem_stallreq) begin
            state_s = IDLE;
          end else begin
            state_s = BUSY;
          end
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
    endcase
    if (bus.flush) begin
      state_s = IDLE;
      cnt_s   = 8'd0;
    end else begin
      cnt_s   = cnt_s;
    end
  end

  // Highest requesting stage sets the stall prefix; everything is masked in reset
  always_comb begin
    stall_s = 6'b000000;
    if (!rst) begin
      stall_s = 6'b000000;
    end else if (mem_req_s) begin
      stall_s = 6'b011111;
    end else if (ex_req_s) begin
      stall_s = 6'b001111;
    end else if (bus.id_stallreq) begin
      stall_s = 6'b000111;
    end else begin
      stall_s = 6'b000000;
    end
  end

  assign bus.stall   = stall_s;
  assign bus.ex_busy = rst & ex_busy_s;
  assign bus.ex_done = rst & ex_done_s;

`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s[0] && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
`else
  assign bus.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed self-checking bench for stall_ctrl (MUL_CYCLES=4, DIV_CYCLES=32).
module tb_stall_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  stall_ctrl_if bus ();

  stall_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [5:0] st, input logic busy, input logic done);
    #1;
    chk({tag, ".stall"}, {26'd0, bus.stall}, {26'd0, st});
    chk({tag, ".busy"}, {31'd0, bus.ex_busy}, {31'd0, busy});
    chk({tag, ".done"}, {31'd0, bus.ex_done}, {31'd0, done});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.id_stallreq  = 1'b1;
    bus.ex_mul_start = 1'b1;
    bus.ex_div_start = 1'b1;
    bus.mem_stallreq = 1'b1;
    bus.flush        = 1'b0;

    // reset held 3 cycles with every request high
    for (int i = 0; i < 3; i++) begin
      chk_out("reset", 6'b000000, 1'b0, 1'b0);
      tick();
    end
    chk("reset.stall_cnt", bus.stall_cnt, 32'd0);
    rst = 1'b1;
    chk_out("post_reset", 6'b011111, 1'b0, 1'b0);
    tick();

    // div was accepted on release; flush it away
    bus.id_stallreq  = 1'b0;
    bus.ex_mul_start = 1'b0;
    bus.ex_div_start = 1'b0;
    bus.mem_stallreq = 1'b0;
    bus.flush        = 1'b1;
    chk_out("flush_cleanup", 6'b001111, 1'b1, 1'b0);
    tick();
    bus.flush = 1'b0;
    chk_out("after_cleanup", 6'b000000, 1'b0, 1'b0);
    tick();

    // load-use single pulse
    bus.id_stallreq = 1'b1;
    chk_out("id_pulse", 6'b000111, 1'b0, 1'b0);
    tick();
    bus.id_stallreq = 1'b0;
    chk_out("id_release", 6'b000000, 1'b0, 1'b0);
    tick();

    // multiply: ex_req t..t+3, done t+4
    bus.ex_mul_start = 1'b1;
    chk_out("mul_t0", 6'b001111, 1'b0, 1'b0);
    tick();
    bus.ex_mul_start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk_out("mul_busy", 6'b001111, 1'b1, 1'b0);
      tick();
    end
    chk_out("mul_done", 6'b000000, 1'b0, 1'b1);
    tick();
    chk_out("mul_idle", 6'b000000, 1'b0, 1'b0);
    tick();

    // div and mul together: div wins, 32 stall cycles
    bus.ex_mul_start = 1'b1;
    bus.ex_div_start = 1'b1;
    chk_out("div_t0", 6'b001111, 1'b0, 1'b0);
    tick();
    bus.ex_mul_start = 1'b0;
    bus.ex_div_start = 1'b0;
    for (int i = 1; i < 32; i++) begin
      chk_out("div_busy", 6'b001111, 1'b1, 1'b0);
      tick();
    end
    chk_out("div_done", 6'b000000, 1'b0, 1'b1);
    tick();
    chk_out("div_idle", 6'b000000, 1'b0, 1'b0);
    tick();

    // multiply with MEM wait t+2..t+6, id request overlapping EX at t+1
    bus.ex_mul_start = 1'b1;
    chk_out("mm_t0", 6'b001111, 1'b0, 1'b0);
    tick();
    bus.ex_mul_start = 1'b0;
    bus.id_stallreq  = 1'b1;
    chk_out("mm_t1_id_vs_ex", 6'b001111, 1'b1, 1'b0);
    tick();
    bus.id_stallreq  = 1'b0;
    bus.mem_stallreq = 1'b1;
    chk_out("mm_t2", 6'b011111, 1'b1, 1'b0);
    tick();
    chk_out("mm_t3", 6'b011111, 1'b1, 1'b0);
    tick();
    for (int i = 4; i <= 6; i++) begin
      chk_out("mm_hold", 6'b011111, 1'b0, 1'b1);
      tick();
    end
    bus.mem_stallreq = 1'b0;
    chk_out("mm_t7", 6'b000000, 1'b0, 1'b1);
    tick();
    chk_out("mm_t8", 6'b000000, 1'b0, 1'b0);
    tick();

    // fresh reset, then div flushed at t+5
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("flush.cnt_cleared", bus.stall_cnt, 32'd0);
    bus.ex_div_start = 1'b1;
    chk_out("fl_t0", 6'b001111, 1'b0, 1'b0);
    tick();
    bus.ex_div_start = 1'b0;
    for (int i = 1; i < 5; i++) begin
      chk_out("fl_busy", 6'b001111, 1'b1, 1'b0);
      tick();
    end
    bus.flush = 1'b1;
    chk_out("fl_t5", 6'b001111, 1'b1, 1'b0);
    tick();
    bus.flush = 1'b0;
    chk_out("fl_t6", 6'b000000, 1'b0, 1'b0);
`ifdef STALL_PERF_EN
    chk("fl.stall_cnt", bus.stall_cnt, 32'd6);
`else
    chk("fl.stall_cnt", bus.stall_cnt, 32'd0);
`endif
    for (int i = 0; i < 30; i++) begin
      tick();
      chk_out("fl_no_done", 6'b000000, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
